// File: rtl/doorlock_pkg.sv
// Shared definitions for the door-lock controller FSM and its keypad code checker.
package doorlock_pkg;

  // Controller FSM state encoding, as seen on the checker's state_i input.
  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StEntCode = 2'b01,
    StSet     = 2'b10,
    StOpen    = 2'b11
  } lock_state_e;

  // Code checker internal state.
  typedef enum logic [1:0] {
    ChkWait,
    ChkCollect,
    ChkLockout
  } chk_state_e;

  localparam int unsigned KeyW = 4;
  typedef logic [KeyW-1:0] key_t;

  localparam key_t DigitMax = key_t'(9);

  function automatic logic key_is_digit(key_t key);
    return key <= DigitMax;
  endfunction

endpackage

// File: rtl/code_shift_reg.sv
// Digit shift buffer with entry count, full flag and parallel compare against a reference code.
module code_shift_reg #(
  parameter int unsigned Digits = 4,
  parameter int unsigned DigitW = 4,
  parameter int unsigned CntW   = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     shift_i,
  input  logic [DigitW-1:0]        digit_i,
  input  logic [Digits*DigitW-1:0] ref_code_i,
  output logic [Digits*DigitW-1:0] code_o,
  output logic [CntW-1:0]          cnt_o,
  output logic                     full_o,
  output logic                     match_o
);

  localparam int unsigned CodeW = Digits * DigitW;

  logic [CodeW-1:0] code_q, code_d, code_base;
  logic [CntW-1:0]  cnt_q, cnt_d, cnt_base;

  // Clear and shift in the same cycle start a fresh entry holding only the new digit.
  always_comb begin
    code_base = clr_i ? '0 : code_q;
    cnt_base  = clr_i ? '0 : cnt_q;
    code_d    = code_base;
    cnt_d     = cnt_base;
    if (shift_i) begin
      code_d = (code_base << DigitW) | CodeW'(digit_i);
      cnt_d  = cnt_base + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      code_q <= '0;
      cnt_q  <= '0;
    end else begin
      code_q <= code_d;
      cnt_q  <= cnt_d;
    end
  end

  assign code_o  = code_q;
  assign cnt_o   = cnt_q;
  assign full_o  = (cnt_q == CntW'(Digits));
  assign match_o = (code_q == ref_code_i);

endmodule

// File: rtl/code_checker.sv
// Keypad passcode checker: collects BCD digits, verifies or stores the code, and
// enforces a lockout after repeated mismatches.
module code_checker
  import doorlock_pkg::*;
#(
  parameter int unsigned             DIGITS         = 4,
  parameter int unsigned             DIGIT_W        = 4,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
  parameter int unsigned             MAX_FAIL       = 3,
  parameter int unsigned             LOCKOUT_CYCLES = 1000,
  parameter int unsigned             CNT_W          = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  state_i,
  input  logic        key_valid_i,
  input  key_t        key_i,
  input  logic        key_clr_i,
  output logic        corr_o,
  output logic        set_o,
  output logic        err_o,
  output logic        lockout_o,
  output logic [3:0]  digit_cnt_o
);

  localparam int unsigned CodeW = DIGITS * DIGIT_W;
  localparam int unsigned FailW = $clog2(MAX_FAIL + 1);

  chk_state_e       st_q;
  lock_state_e      mode_q;
  lock_state_e      state_in;
  logic [CodeW-1:0] stored_q;
  logic [FailW-1:0] fail_q, fail_inc;
  logic [CNT_W-1:0] lock_cnt_q;
  logic             corr_q, set_q, err_q, lockout_q;

  logic             entry_mode, key_ok, evaluate, abort, lock_trip;
  logic             sr_clr, sr_shift;
  logic [CodeW-1:0] buf_code;
  logic             buf_full, buf_match;

  assign state_in = lock_state_e'(state_i);

  always_comb begin
    entry_mode = (state_in == StEntCode) || (state_in == StSet);
    key_ok     = key_valid_i && key_is_digit(key_i) && entry_mode && !key_clr_i &&
                 (st_q != ChkLockout);
    evaluate   = (st_q == ChkCollect) && buf_full;
    // A completed entry is always evaluated; clear or mode change only aborts partial ones.
    abort      = (st_q == ChkCollect) && !buf_full && (key_clr_i || (state_in != mode_q));
    fail_inc   = fail_q + FailW'(1);
    lock_trip  = evaluate && (mode_q == StEntCode) && !buf_match &&
                 (fail_inc >= FailW'(MAX_FAIL));
    sr_clr     = evaluate || abort;
    sr_shift   = key_ok && !abort && !lock_trip;
  end

  code_shift_reg #(
    .Digits (DIGITS),
    .DigitW (DIGIT_W),
    .CntW   (4)
  ) u_shift_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (sr_clr),
    .shift_i    (sr_shift),
    .digit_i    (DIGIT_W'(key_i)),
    .ref_code_i (stored_q),
    .code_o     (buf_code),
    .cnt_o      (digit_cnt_o),
    .full_o     (buf_full),
    .match_o    (buf_match)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q       <= ChkWait;
      mode_q     <= StIdle;
      stored_q   <= DEFAULT_CODE;
      fail_q     <= '0;
      lock_cnt_q <= '0;
      corr_q     <= 1'b0;
      set_q      <= 1'b0;
      err_q      <= 1'b0;
      lockout_q  <= 1'b0;
    end else begin
      corr_q <= 1'b0;
      set_q  <= 1'b0;
      err_q  <= 1'b0;
      unique case (st_q)
        ChkWait: begin
          if (key_ok) begin
            mode_q <= state_in;
            st_q   <= ChkCollect;
          end
        end
        ChkCollect: begin
          if (evaluate) begin
            if (mode_q == StSet) begin
              stored_q <= buf_code;
              set_q    <= 1'b1;
            end else if (buf_match) begin
              corr_q <= 1'b1;
              fail_q <= '0;
            end else begin
              err_q  <= 1'b1;
              fail_q <= fail_inc;
            end
            if (lock_trip) begin
              st_q       <= ChkLockout;
              lock_cnt_q <= CNT_W'(LOCKOUT_CYCLES - 1);
              lockout_q  <= 1'b1;
            end else if (key_ok) begin
              mode_q <= state_in;
            end else begin
              st_q <= ChkWait;
            end
          end else if (abort) begin
            st_q <= ChkWait;
          end
        end
        ChkLockout: begin
          if (lock_cnt_q == '0) begin
            lockout_q <= 1'b0;
            fail_q    <= '0;
            st_q      <= ChkWait;
          end else begin
            lock_cnt_q <= lock_cnt_q - CNT_W'(1);
          end
        end
        default: st_q <= ChkWait;
      endcase
    end
  end

  assign corr_o    = corr_q;
  assign set_o     = set_q;
  assign err_o     = err_q;
  assign lockout_o = lockout_q;

endmodule

// File: tb/tb_code_checker.sv
// Self-checking bench for code_checker: directed vector table, hand sequences and random stimulus.
module tb_code_checker;

  localparam int unsigned Digits     = 4;
  localparam int unsigned DigitW     = 4;
  localparam int unsigned MaxFail    = 3;
  localparam int unsigned LockCycles = 8;
  localparam int unsigned CntW       = 4;
  localparam logic [15:0] DefCode    = 16'h1234;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [1:0] state_i;
  logic       key_valid_i;
  logic [3:0] key_i;
  logic       key_clr_i;
  logic       corr_o, set_o, err_o, lockout_o;
  logic [3:0] digit_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  code_checker #(
    .DIGITS         (Digits),
    .DIGIT_W        (DigitW),
    .DEFAULT_CODE   (DefCode),
    .MAX_FAIL       (MaxFail),
    .LOCKOUT_CYCLES (LockCycles),
    .CNT_W          (CntW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .state_i     (state_i),
    .key_valid_i (key_valid_i),
    .key_i       (key_i),
    .key_clr_i   (key_clr_i),
    .corr_o      (corr_o),
    .set_o       (set_o),
    .err_o       (err_o),
    .lockout_o   (lockout_o),
    .digit_cnt_o (digit_cnt_o)
  );

  // Reference model: digits as a queue, stored code as a digit array, lockout as cycles left.
  int m_q[$];
  int m_mode;
  int m_code[Digits];
  int m_fail;
  bit m_locked;
  int m_left;
  bit m_corr, m_set, m_err, m_lock;

  task automatic model_reset();
    m_q.delete();
    m_mode   = 0;
    for (int i = 0; i < Digits; i++)
      m_code[i] = int'((DefCode >> (DigitW * (Digits - 1 - i))) & 16'hF);
    m_fail   = 0;
    m_locked = 0;
    m_left   = 0;
    m_corr   = 0;
    m_set    = 0;
    m_err    = 0;
    m_lock   = 0;
  endtask

  task automatic model_step(input int st, input int kv, input int k, input int clr, input int rst);
    bit accept;
    bit match;
    m_corr = 0;
    m_set  = 0;
    m_err  = 0;
    if (rst != 0) begin
      model_reset();
      return;
    end
    accept = (kv != 0) && (k <= 9) && (st == 1 || st == 2) && (clr == 0);
    if (m_locked) begin
      if (m_left == 0) begin
        m_locked = 0;
        m_lock   = 0;
        m_fail   = 0;
      end else begin
        m_left--;
      end
    end else if (m_q.size() == Digits) begin
      match = 1;
      for (int i = 0; i < Digits; i++)
        if (m_q[i] != m_code[i]) match = 0;
      if (m_mode == 2) begin
        for (int i = 0; i < Digits; i++) m_code[i] = m_q[i];
        m_set = 1;
      end else if (match) begin
        m_corr = 1;
        m_fail = 0;
      end else begin
        m_err = 1;
        m_fail++;
      end
      m_q.delete();
      if (m_fail >= MaxFail) begin
        m_locked = 1;
        m_left   = LockCycles - 1;
        m_lock   = 1;
      end else if (accept) begin
        m_q.push_back(k);
        m_mode = st;
      end
    end else if (m_q.size() > 0 && (clr != 0 || st != m_mode)) begin
      m_q.delete();
    end else if (accept) begin
      if (m_q.size() == 0) m_mode = st;
      m_q.push_back(k);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, step model, compare every output with the model.
  task automatic tick(input int st, input int kv, input int key, input int clr, input int rst);
    state_i     = 2'(st);
    key_valid_i = 1'(kv);
    key_i       = 4'(key);
    key_clr_i   = 1'(clr);
    rst_i       = 1'(rst);
    @(posedge clk);
    #1;
    model_step(st, kv, key, clr, rst);
    chk("model.corr_o", int'(corr_o), int'(m_corr));
    chk("model.set_o", int'(set_o), int'(m_set));
    chk("model.err_o", int'(err_o), int'(m_err));
    chk("model.lockout_o", int'(lockout_o), int'(m_lock));
    chk("model.digit_cnt_o", int'(digit_cnt_o), m_q.size());
  endtask

  task automatic expect_out(input string tag, input int c, input int s, input int e,
                            input int l, input int n);
    chk({tag, ".corr_o"}, int'(corr_o), c);
    chk({tag, ".set_o"}, int'(set_o), s);
    chk({tag, ".err_o"}, int'(err_o), e);
    chk({tag, ".lockout_o"}, int'(lockout_o), l);
    chk({tag, ".digit_cnt_o"}, int'(digit_cnt_o), n);
  endtask

  task automatic enter4(input int st, input int a, input int b, input int c, input int d);
    tick(st, 1, a, 0, 0);
    tick(st, 1, b, 0, 0);
    tick(st, 1, c, 0, 0);
    tick(st, 1, d, 0, 0);
  endtask

  typedef struct {
    int st; int kv; int key; int clr;
    int corr; int set; int err; int lock; int cnt;
  } vec_t;

  function automatic vec_t mk(int st, int kv, int key, int clr,
                              int corr, int set, int err, int lock, int cnt);
    vec_t v;
    v.st = st; v.kv = kv; v.key = key; v.clr = clr;
    v.corr = corr; v.set = set; v.err = err; v.lock = lock; v.cnt = cnt;
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st_r;
    int kv_r, key_r, clr_r, rst_r;

    state_i = 2'b00; key_valid_i = 0; key_i = 0; key_clr_i = 0; rst_i = 1;
    model_reset();
    tick(1, 1, 1, 0, 1);
    tick(0, 0, 0, 0, 1);
    expect_out("reset", 0, 0, 0, 0, 0);

    // Directed vectors from reset: {st, kv, key, clr} -> {corr, set, err, lock, cnt}.
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 12, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 3, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 1, 5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2, 1, 9, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2, 1, 8, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(2, 1, 7, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(2, 1, 6, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(2, 0, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 4, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 1, 9, 0, 0, 0, 1, 0, 1));
    vecs.push_back(mk(1, 1, 8, 0, 0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 3));
    vecs.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].st, vecs[i].kv, vecs[i].key, vecs[i].clr, 0);
      expect_out($sformatf("vec%0d", i), vecs[i].corr, vecs[i].set, vecs[i].err,
                 vecs[i].lock, vecs[i].cnt);
    end

    // Reset mid-entry restores the default code.
    enter4(2, 5, 5, 5, 5);
    tick(2, 0, 0, 0, 0);
    expect_out("set5555", 0, 1, 0, 0, 0);
    tick(1, 1, 1, 0, 0);
    tick(1, 1, 2, 0, 0);
    expect_out("partial", 0, 0, 0, 0, 2);
    tick(1, 0, 0, 0, 1);
    expect_out("midreset", 0, 0, 0, 0, 0);
    enter4(1, 1, 2, 3, 4);
    tick(1, 0, 0, 0, 0);
    expect_out("default_after_reset", 1, 0, 0, 0, 0);

    // Three mismatches trip the lockout together with the third err_o.
    for (int n = 0; n < 3; n++) begin
      enter4(1, 1, 2, 3, 5);
      tick(1, 0, 0, 0, 0);
      expect_out($sformatf("wrong%0d", n), 0, 0, 1, (n == 2) ? 1 : 0, 0);
    end
    for (int i = 1; i < LockCycles; i++) begin
      tick(1, 1, 1, 0, 0);
      expect_out($sformatf("locked%0d", i), 0, 0, 0, 1, 0);
    end
    tick(1, 1, 1, 0, 0);
    expect_out("lock_release", 0, 0, 0, 0, 0);
    enter4(1, 1, 2, 3, 4);
    tick(1, 0, 0, 0, 0);
    expect_out("after_lockout", 1, 0, 0, 0, 0);

    // Random stimulus against the model; keys are often steered toward the stored code.
    st_r = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 99) < 5) st_r = int'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 3) st_r = 1;
      kv_r = ($urandom_range(0, 99) < 60) ? 1 : 0;
      if ($urandom_range(0, 1) == 1 && m_q.size() < Digits)
        key_r = m_code[m_q.size()];
      else
        key_r = int'($urandom_range(0, 15));
      clr_r = ($urandom_range(0, 99) < 3) ? 1 : 0;
      rst_r = ($urandom_range(0, 999) < 5) ? 1 : 0;
      tick(st_r, kv_r, key_r, clr_r, rst_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
